// File: rtl/hdmi_line_fetch.sv
`default_nettype none
// hdmi_line_fetch: bursts frame lines from memory into a ping-pong line buffer
// and streams the displayed line to hdmi_core, one pixel per pix_rd.
module hdmi_line_fetch #(
  parameter int PIX_W      = 24,
  parameter int LINE_DEPTH = 2048
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      frame_base,
  input  logic [10:0]      hres,
  input  logic [9:0]       vres,
  input  logic             read_go,
  input  logic             read_next_line,
  input  logic             read_done,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [10:0]      mem_len,
  input  logic             mem_ack,
  input  logic [PIX_W-1:0] mem_rdata,
  input  logic             mem_rvalid,
  input  logic             pix_rd,
  output logic [PIX_W-1:0] pix_data,
  output logic             line_ready,
  output logic             underrun
);
  localparam int AW = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FILL  = 3'd2,
    WAIT  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [10:0]      hres_q, hres_d, wptr_q, wptr_d, rptr_q, rptr_d;
  logic [10:0]      flush_cnt_q, flush_cnt_d, mem_len_q, mem_len_d;
  logic [9:0]       vres_q, vres_d, line_cnt_q, line_cnt_d;
  logic [31:0]      cur_addr_q, cur_addr_d, mem_addr_q, mem_addr_d;
  logic             wbuf_q, wbuf_d, rbuf_q, rbuf_d;
  logic             pend_q, pend_d, done_pend_q, done_pend_d;
  logic             mem_req_q, mem_req_d, underrun_q, underrun_d;
  logic             line_ready_q, line_ready_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;

  logic [PIX_W-1:0] line_mem [0:2*LINE_DEPTH-1];
  logic             we, issue, swap, last_beat;
  logic [10:0]      remain;
  logic [AW:0]      waddr, raddr;

  assign waddr     = {wbuf_q, AW'(wptr_q)};
  assign raddr     = {rbuf_q, AW'(rptr_q)};
  assign last_beat = mem_rvalid && (wptr_q == hres_q - 11'd1);
  // Beats still owed by memory when a frame is aborted mid-line.
  assign remain    = hres_q - wptr_q - {10'd0, mem_rvalid};

  always_comb begin
    state_d      = state_q;
    hres_d       = hres_q;
    vres_d       = vres_q;
    cur_addr_d   = cur_addr_q;
    line_cnt_d   = line_cnt_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    wbuf_d       = wbuf_q;
    rbuf_d       = rbuf_q;
    pend_d       = pend_q;
    done_pend_d  = done_pend_q;
    flush_cnt_d  = flush_cnt_q;
    underrun_d   = underrun_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_len_d    = mem_len_q;
    we           = 1'b0;
    issue        = 1'b0;
    swap         = 1'b0;

    if (pix_rd && (rptr_q != hres_q - 11'd1)) rptr_d = rptr_q + 11'd1;
    if (read_done) pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (read_done) begin
          state_d = IDLE;
        end else if (read_go) begin
          hres_d     = hres;
          vres_d     = vres;
          line_cnt_d = '0;
          cur_addr_d = frame_base;
          wbuf_d     = 1'b0;
          underrun_d = 1'b0;
          issue      = 1'b1;
        end else if (read_next_line) begin
          rptr_d = '0;
        end
      end
      REQ: begin
        if (read_done) begin
          done_pend_d = 1'b1;
        end else if (read_next_line && !done_pend_q) begin
          underrun_d = 1'b1;
          pend_d     = 1'b1;
        end
        if (mem_ack) begin
          mem_req_d = 1'b0;
          wptr_d    = '0;
          if (read_done || done_pend_q) begin
            state_d     = FLUSH;
            flush_cnt_d = hres_q;
            done_pend_d = 1'b0;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (read_done) begin
          state_d     = (remain == 11'd0) ? IDLE : FLUSH;
          flush_cnt_d = remain;
        end else begin
          if (mem_rvalid) begin
            we     = 1'b1;
            wptr_d = wptr_q + 11'd1;
          end
          // A switch landing on the final beat is on time; the swap itself
          // happens from WAIT on the following cycle.
          if (last_beat) begin
            line_cnt_d = line_cnt_q + 10'd1;
            cur_addr_d = cur_addr_q + {19'd0, hres_q, 2'b00};
            state_d    = WAIT;
            pend_d     = pend_q || read_next_line;
          end else if (read_next_line) begin
            underrun_d = 1'b1;
            pend_d     = 1'b1;
          end
        end
      end
      WAIT: begin
        if (read_done) state_d = IDLE;
        else if (read_next_line || pend_q) swap = 1'b1;
      end
      FLUSH: begin
        if (mem_rvalid) begin
          flush_cnt_d = flush_cnt_q - 11'd1;
          if (flush_cnt_q == 11'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (swap) begin
      rbuf_d = wbuf_q;
      wbuf_d = ~wbuf_q;
      rptr_d = '0;
      pend_d = 1'b0;
      if (line_cnt_q < vres_q) issue = 1'b1;
      else                     state_d = IDLE;
    end

    if (issue) begin
      state_d    = REQ;
      mem_req_d  = 1'b1;
      mem_addr_d = cur_addr_d;
      mem_len_d  = hres_d;
    end

    line_ready_d = (state_d == WAIT);
    pix_data_d   = pix_rd ? line_mem[raddr] : pix_data_q;
  end

  always_ff @(posedge clock) begin
    if (we) line_mem[waddr] <= mem_rdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hres_q       <= '0;
      vres_q       <= '0;
      cur_addr_q   <= '0;
      line_cnt_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      wbuf_q       <= 1'b0;
      rbuf_q       <= 1'b0;
      pend_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      flush_cnt_q  <= '0;
      underrun_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_len_q    <= '0;
      line_ready_q <= 1'b0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      hres_q       <= hres_d;
      vres_q       <= vres_d;
      cur_addr_q   <= cur_addr_d;
      line_cnt_q   <= line_cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      wbuf_q       <= wbuf_d;
      rbuf_q       <= rbuf_d;
      pend_q       <= pend_d;
      done_pend_q  <= done_pend_d;
      flush_cnt_q  <= flush_cnt_d;
      underrun_q   <= underrun_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_len_q    <= mem_len_d;
      line_ready_q <= line_ready_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_len    = mem_len_q;
  assign pix_data   = pix_data_q;
  assign line_ready = line_ready_q;
  assign underrun   = underrun_q;
endmodule
`default_nettype wire

// File: tb/tb_hdmi_line_fetch.sv
`default_nettype none
// Scoreboard bench for hdmi_line_fetch: a memory model feeds beats, expected
// pixels are queued as beats are driven and compared as pixels are read.
module tb_hdmi_line_fetch;
  localparam int PIX_W = 24;

  logic             clock, reset;
  logic [31:0]      frame_base;
  logic [10:0]      hres;
  logic [9:0]       vres;
  logic             read_go, read_next_line, read_done;
  logic             mem_req, mem_ack, mem_rvalid;
  logic [31:0]      mem_addr;
  logic [10:0]      mem_len;
  logic [PIX_W-1:0] mem_rdata, pix_data;
  logic             pix_rd, line_ready, underrun;

  int errors = 0;
  int checks = 0;
  logic [PIX_W-1:0] sb[$];
  logic [PIX_W-1:0] got[$];

  hdmi_line_fetch #(.PIX_W(PIX_W), .LINE_DEPTH(2048)) dut (
    .clock(clock), .reset(reset), .frame_base(frame_base), .hres(hres), .vres(vres),
    .read_go(read_go), .read_next_line(read_next_line), .read_done(read_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .pix_rd(pix_rd),
    .pix_data(pix_data), .line_ready(line_ready), .underrun(underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic beats(input int n, input logic [PIX_W-1:0] base, input bit push);
    for (int i = 0; i < n; i++) begin
      mem_rdata  = base + PIX_W'(i);
      mem_rvalid = 1'b1;
      if (push) sb.push_back(base + PIX_W'(i));
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic pulse_go(input logic [31:0] base, input logic [10:0] h, input logic [9:0] v);
    frame_base = base;
    hres       = h;
    vres       = v;
    read_go    = 1'b1;
    tick();
    read_go    = 1'b0;
  endtask

  task automatic pulse_rnl();
    read_next_line = 1'b1;
    tick();
    read_next_line = 1'b0;
  endtask

  task automatic pulse_done();
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
  endtask

  task automatic read_pix(input int n);
    for (int i = 0; i < n; i++) begin
      pix_rd = 1'b1;
      tick();
      got.push_back(pix_data);
    end
    pix_rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_len !== 11'h0) begin errors++; $display("FAIL reset_mem_len: got %h expected 0", mem_len); end
    checks++; if (pix_data !== '0) begin errors++; $display("FAIL reset_pix_data: got %h expected 0", pix_data); end
    checks++; if (line_ready !== 1'b0) begin errors++; $display("FAIL reset_line_ready: got %b expected 0", line_ready); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int seen;
    logic [PIX_W-1:0] e, a;
    pulse_go(32'h1000, 11'd4, 10'd2);
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_req0: got no mem_req expected mem_req"); end
    checks++; if (mem_addr !== 32'h1000 || mem_len !== 11'd4) begin errors++; $display("FAIL basic_req0_fields: got addr %h len %0d expected 1000 len 4", mem_addr, mem_len); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin errors++; $display("FAIL basic_req_hold: got req %b addr %h expected 1 1000", mem_req, mem_addr); end
    ack();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b expected 0", mem_req); end
    beats(4, 24'hA00000, 1'b1);
    checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL basic_line_ready: got %b expected 1", line_ready); end
    pulse_rnl();
    checks++; if (line_ready !== 1'b0) begin errors++; $display("FAIL basic_line_ready_clr: got %b expected 0", line_ready); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1010 || mem_len !== 11'd4) begin errors++; $display("FAIL basic_req1: got req %b addr %h len %0d expected 1 1010 4", mem_req, mem_addr, mem_len); end
    read_pix(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb.size() == 0 || got.size() == 0) begin errors++; $display("FAIL basic_pix_line0: got empty queue expected pixel"); end
      else begin
        e = sb.pop_front(); a = got.pop_front();
        if (a !== e) begin errors++; $display("FAIL basic_pix_line0[%0d]: got %h expected %h", i, a, e); end
      end
    end
    ack();
    beats(4, 24'hB00000, 1'b1);
    pulse_rnl();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req === 1'b1) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL basic_frame_end: got %0d mem_req cycles expected 0", seen); end
    read_pix(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb.size() == 0 || got.size() == 0) begin errors++; $display("FAIL basic_pix_line1: got empty queue expected pixel"); end
      else begin
        e = sb.pop_front(); a = got.pop_front();
        if (a !== e) begin errors++; $display("FAIL basic_pix_line1[%0d]: got %h expected %h", i, a, e); end
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    logic [PIX_W-1:0] e, a;
    pulse_go(32'h2000, 11'd4, 10'd2);
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL underrun_req0: got no mem_req expected mem_req"); end
    ack();
    beats(2, 24'hC00000, 1'b1);
    pulse_rnl();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
    beats(2, 24'hC00002, 1'b1);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2010) begin errors++; $display("FAIL underrun_swap_req: got req %b addr %h expected 1 2010", mem_req, mem_addr); end
    read_pix(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb.size() == 0 || got.size() == 0) begin errors++; $display("FAIL underrun_pix: got empty queue expected pixel"); end
      else begin
        e = sb.pop_front(); a = got.pop_front();
        if (a !== e) begin errors++; $display("FAIL underrun_pix[%0d]: got %h expected %h", i, a, e); end
      end
    end
    pulse_done();
    ack();
    beats(4, 24'hEE0000, 1'b0);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
  endtask

  task automatic test_flush();
    bit ok;
    logic [PIX_W-1:0] e, a;
    pulse_go(32'h3000, 11'd4, 10'd2);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL flush_go_clears_underrun: got %b expected 0", underrun); end
    checks++; if (mem_addr !== 32'h3000) begin errors++; $display("FAIL flush_req_addr: got %h expected 3000", mem_addr); end
    ack();
    beats(1, 24'hD00000, 1'b0);
    pulse_done();
    beats(3, 24'hE00001, 1'b0);
    pulse_rnl();
    // buffer 0 keeps C1..C3 from the earlier line; only D0 replaced slot 0
    sb.push_back(24'hD00000);
    sb.push_back(24'hC00001);
    sb.push_back(24'hC00002);
    sb.push_back(24'hC00003);
    read_pix(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb.size() == 0 || got.size() == 0) begin errors++; $display("FAIL flush_pix: got empty queue expected pixel"); end
      else begin
        e = sb.pop_front(); a = got.pop_front();
        if (a !== e) begin errors++; $display("FAIL flush_pix[%0d]: got %h expected %h", i, a, e); end
      end
    end
    pulse_go(32'h3000, 11'd4, 10'd2);
    wait_req(ok);
    checks++; if (!ok || mem_addr !== 32'h3000) begin errors++; $display("FAIL flush_restart: got req %b addr %h expected 1 3000", mem_req, mem_addr); end
  endtask

  task automatic test_ontime();
    logic [PIX_W-1:0] e, a;
    ack();
    beats(3, 24'hF00000, 1'b1);
    mem_rdata      = 24'hF00003;
    mem_rvalid     = 1'b1;
    read_next_line = 1'b1;
    sb.push_back(24'hF00003);
    tick();
    mem_rvalid     = 1'b0;
    read_next_line = 1'b0;
    tick();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ontime_no_underrun: got %b expected 0", underrun); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3010) begin errors++; $display("FAIL ontime_next_req: got req %b addr %h expected 1 3010", mem_req, mem_addr); end
    read_pix(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb.size() == 0 || got.size() == 0) begin errors++; $display("FAIL ontime_pix: got empty queue expected pixel"); end
      else begin
        e = sb.pop_front(); a = got.pop_front();
        if (a !== e) begin errors++; $display("FAIL ontime_pix[%0d]: got %h expected %h", i, a, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [PIX_W-1:0] e, a;
    ack();
    beats(2, 24'h900000, 1'b0);
    pulse_rnl();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL rstmid_pre_underrun: got %b expected 1", underrun); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_len !== 11'h0) begin errors++; $display("FAIL rstmid_mem: got req %b addr %h len %0d expected 0 0 0", mem_req, mem_addr, mem_len); end
    checks++; if (pix_data !== '0 || underrun !== 1'b0 || line_ready !== 1'b0) begin errors++; $display("FAIL rstmid_outs: got pix %h underrun %b ready %b expected 0 0 0", pix_data, underrun, line_ready); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    pulse_go(32'h4000, 11'd3, 10'd1);
    wait_req(ok);
    checks++; if (!ok || mem_addr !== 32'h4000 || mem_len !== 11'd3) begin errors++; $display("FAIL rstmid_req: got req %b addr %h len %0d expected 1 4000 3", mem_req, mem_addr, mem_len); end
    ack();
    beats(3, 24'h500000, 1'b1);
    checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL rstmid_line_ready: got %b expected 1", line_ready); end
    pulse_rnl();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_last_line: got %b expected 0", mem_req); end
    sb.push_back(24'h500002);  // fourth read saturates at hres-1
    read_pix(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb.size() == 0 || got.size() == 0) begin errors++; $display("FAIL rstmid_pix: got empty queue expected pixel"); end
      else begin
        e = sb.pop_front(); a = got.pop_front();
        if (a !== e) begin errors++; $display("FAIL rstmid_pix[%0d]: got %h expected %h", i, a, e); end
      end
    end
  endtask

  initial begin
    reset          = 1'b0;
    frame_base     = '0;
    hres           = '0;
    vres           = '0;
    read_go        = 1'b0;
    read_next_line = 1'b0;
    read_done      = 1'b0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    mem_rvalid     = 1'b0;
    pix_rd         = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_flush();
    test_ontime();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hdmi_line_fetch.md
HDMI_LINE_FETCH -- requirements
Module: hdmi_line_fetch

Interface
REQ-001 SHALL have parameter PIX_W, default 24: pixel width in bits.
REQ-002 SHALL have parameter LINE_DEPTH, default 2048: pixels per line buffer; two buffers (ping-pong).
REQ-003 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port frame_base, input, 32: frame byte address, sampled on accepted read_go.
REQ-006 SHALL have port hres, input, 11: pixels per line, 1..LINE_DEPTH, sampled on accepted read_go.
REQ-007 SHALL have port vres, input, 10: lines per frame, at least 1, sampled on accepted read_go.
REQ-008 SHALL have port read_go, input, 1: start-of-frame pulse from hdmi_core.
REQ-009 SHALL have port read_next_line, input, 1: display line-switch pulse from hdmi_core.
REQ-010 SHALL have port read_done, input, 1: end-of-frame pulse from hdmi_core.
REQ-011 SHALL have ports mem_req out 1, mem_addr out 32, mem_len out 11 (beats), and mem_ack in 1: burst read request handshake.
REQ-012 SHALL have ports mem_rdata in PIX_W and mem_rvalid in 1: read data beats, in order, one pixel per beat.
REQ-013 SHALL have ports pix_rd in 1 (driven by hdmi_core ve) and pix_data out PIX_W: pixel stream to hdmi_core.
REQ-014 SHALL have ports line_ready out 1 (fill buffer complete, awaiting swap) and underrun out 1 (sticky error).

Function
REQ-015 SHALL implement FSM states IDLE, REQ, FILL, WAIT, FLUSH.
REQ-016 IDLE, read_go=1: latch inputs; line_cnt=0; cur_addr=frame_base; wbuf=0; go to REQ. read_go outside IDLE is ignored.
REQ-017 REQ behaviour:
- mem_req=1, mem_addr=cur_addr, mem_len=hres.
- mem_req, mem_addr and mem_len held stable until the mem_ack cycle.
- mem_ack=1: go to FILL with wptr=0.
REQ-018 FILL behaviour:
- Each mem_rvalid beat writes mem_rdata to buffer[wbuf][wptr]; wptr increments.
- Beat with wptr==hres-1: line_cnt+1; cur_addr+=hres*4 (32-bit add, wraps modulo 2^32); go to WAIT.
REQ-019 WAIT: line_ready=1; line_ready=0 in all other states.
REQ-020 Swap on read_next_line in WAIT, or on pending swap at fill completion:
- rbuf=wbuf; wbuf flips; rptr=0.
- Go to REQ if line_cnt<vres, else IDLE.
REQ-021 read_next_line in REQ or FILL: set underrun and a pending-swap flag; the swap occurs on the cycle after the last beat.
REQ-022 read_next_line on the same cycle as the last FILL beat counts as on time: no underrun.
REQ-023 read_next_line in IDLE: rbuf unchanged; rptr=0.
REQ-024 pix_data: registered; one-cycle latency from pix_rd; value buffer[rbuf][rptr].
- rptr increments per pix_rd, saturating at hres-1.
- pix_data holds its value when pix_rd=0.
REQ-025 read_done, by state:
- IDLE or WAIT: go to IDLE.
- FILL: go to FLUSH, discarding hres-wptr remaining beats, then IDLE.
- REQ: complete the handshake, then FLUSH hres beats.
- Pending-swap flag is cleared in all cases.
REQ-026 read_done SHALL take priority over read_next_line and read_go on the same cycle.
REQ-027 Beats in FLUSH SHALL NOT write either buffer; mem_rvalid in IDLE, REQ or WAIT is ignored.
REQ-028 underrun SHALL clear only on reset or on an accepted read_go.

Reset
REQ-029 Reset SHALL force:
- state=IDLE.
- mem_req=0, mem_addr=0, mem_len=0.
- pix_data=0, line_ready=0, underrun=0.
- line_cnt=0, wptr=0, rptr=0, wbuf=0, rbuf=0; pending-swap flag cleared.
REQ-030 Reset asserted mid-burst SHALL abandon the burst without flushing; buffer contents are don't-care.

Verification
REQ-031 hres=4, vres=2, frame_base=0x1000, read_go → mem_req with addr 0x1000, len 4. Ack, then 4 beats A0..A3 → line_ready=1.
REQ-032 Continue REQ-031, read_next_line:
- mem_req with addr 0x1010, len 4.
- 4× pix_rd → pix_data A0,A1,A2,A3, each one cycle after its pix_rd.
- Fill line 1 then read_next_line → IDLE; no further mem_req.
REQ-033 read_next_line during FILL after beat 2 of 4 → underrun=1. Swap occurs the cycle after beat 4; pix_data then returns the new line.
REQ-034 read_done after beat 1 of 4 → FLUSH consumes 3 beats, buffers unchanged, then IDLE. Next read_go → underrun=0, addr=frame_base.
REQ-035 read_next_line on the same cycle as the final beat → no underrun; swap occurs; next mem_req issued.
REQ-036 Reset asserted during FILL → all outputs at reset values; fresh read_go → normal fetch from frame_base.
